seg_scan_ctrl: RTL

Parametrised multiplexed 7-segment scan controller, successor to the fixed 6-digit BCD driver. It time-multiplexes DIGITS common-anode/cathode digits from a packed nibble bus. Over the old driver it adds hex decoding, leading-zero blanking, per-digit blink, PWM brightness, frame-coherent input capture and selectable output polarity. It sits between the display-value logic and the board's digit-select and segment pins.

---
 rtl/seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: hex/BCD decode, leading-zero blanking, blink, PWM dimming.
// Latency: sel/seg_led are registered and show a new digit one clk after the slot strobe.
// Backpressure: none; free-running scan, inputs are sampled once per frame into shadow registers.
module seg_scan_ctrl #(
   parameter int DIGITS         = 6,
   parameter int SCAN_DIV       = 10000,
   parameter int BLINK_DIV      = 250,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] num,
   input  logic [DIGITS-1:0]   point,
   input  logic [DIGITS-1:0]   blink,
   input  logic                hex_en,
   input  logic                lz_blank,
   input  logic [3:0]          bright,
   output logic [DIGITS-1:0]   sel,
   output logic [7:0]          seg_led,
   output logic                frame_tick
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // ST_WAIT keeps the display dark until the first slot after reset
   typedef enum logic {ST_WAIT, ST_SCAN} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic                bph_q, bph_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic [4*DIGITS-1:0] num_sh_q, num_sh_d;
   logic [DIGITS-1:0]   point_sh_q, point_sh_d;
   logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
   logic                hex_sh_q, hex_sh_d;
   logic                lz_sh_q, lz_sh_d;
   logic [DIGITS-1:0]   sel_q;
   logic [7:0]          seg_q;
   logic                ft_q;

   logic                slot_tick;
   logic                snap;
   logic                wrap;
   logic                zero_run;
   logic [DIGITS-1:0]   lz_vec;
   logic [DIGITS-1:0]   onehot;
   logic [3:0]          nib;
   logic                dp_bit;
   logic                blink_bit;
   logic                blank_bit;
   logic [7:0]          seg_int;
   logic [DIGITS-1:0]   sel_int;

   // active-high gfedcba pattern for one nibble
   function automatic logic [6:0] dec7(input logic [3:0] v, input logic hex);
      logic [6:0] r;
      case (v)
         4'h0: r = 7'h3F;
         4'h1: r = 7'h06;
         4'h2: r = 7'h5B;
         4'h3: r = 7'h4F;
         4'h4: r = 7'h66;
         4'h5: r = 7'h6D;
         4'h6: r = 7'h7D;
         4'h7: r = 7'h07;
         4'h8: r = 7'h7F;
         4'h9: r = 7'h6F;
         4'hA: r = 7'h77;
         4'hB: r = 7'h7C;
         4'hC: r = 7'h39;
         4'hD: r = 7'h5E;
         4'hE: r = 7'h79;
         default: r = 7'h71;
      endcase
      if (!hex && (v > 4'h9)) r = 7'h00;
      return r;
   endfunction

   // slot prescaler and free-running PWM phase counter
   always_comb begin
      slot_tick = (pcnt_q == PW'(SCAN_DIV - 1));
      pcnt_d    = slot_tick ? '0 : pcnt_q + PW'(1);
      wcnt_d    = wcnt_q + 4'd1;
   end

   // digit sequencing; frame start (first slot or idx wrap) triggers the snapshot
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap    = 1'b0;
      wrap    = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (slot_tick) begin
               state_d = ST_SCAN;
               idx_d   = '0;
               snap    = 1'b1;
            end
         end
         ST_SCAN: begin
            if (slot_tick) begin
               if (idx_q == IW'(DIGITS - 1)) begin
                  idx_d = '0;
                  snap  = 1'b1;
                  wrap  = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_WAIT;
      else        state_q <= state_d;
   end

   // blink frame counter; only real frame wraps count, not the post-reset start
   always_comb begin
      bcnt_d = bcnt_q;
      bph_d  = bph_q;
      if (wrap) begin
         if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   // frame-coherent shadow copies of the display inputs
   always_comb begin
      num_sh_d   = num_sh_q;
      point_sh_d = point_sh_q;
      blink_sh_d = blink_sh_q;
      hex_sh_d   = hex_sh_q;
      lz_sh_d    = lz_sh_q;
      if (snap) begin
         num_sh_d   = num;
         point_sh_d = point;
         blink_sh_d = blink;
         hex_sh_d   = hex_en;
         lz_sh_d    = lz_blank;
      end
   end

   // next-cycle digit image, built from next-state values so outputs track idx with one clk latency
   always_comb begin
      zero_run  = 1'b1;
      lz_vec    = '0;
      onehot    = '0;
      nib       = 4'h0;
      dp_bit    = 1'b0;
      blink_bit = 1'b0;
      blank_bit = 1'b0;
      seg_int   = 8'h00;
      sel_int   = '0;
      // a digit is a leading zero if it and every digit to its left are zero; digit 0 never is
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run  = zero_run & (num_sh_d[4*i +: 4] == 4'h0);
         lz_vec[i] = zero_run & (i != 0);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_d) begin
            nib       = num_sh_d[4*i +: 4];
            dp_bit    = point_sh_d[i];
            blink_bit = blink_sh_d[i];
            blank_bit = lz_sh_d & lz_vec[i];
            onehot[i] = 1'b1;
         end
      end
      if (state_d == ST_SCAN) begin
         if (!(blink_bit && bph_d)) seg_int = {dp_bit, blank_bit ? 7'h00 : dec7(nib, hex_sh_d)};
         if (wcnt_d <= bright)      sel_int = onehot;
      end
   end

   // counters, shadows and polarity-adjusted output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q     <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         bph_q      <= 1'b0;
         wcnt_q     <= 4'd0;
         num_sh_q   <= '0;
         point_sh_q <= '0;
         blink_sh_q <= '0;
         hex_sh_q   <= 1'b0;
         lz_sh_q    <= 1'b0;
         sel_q      <= {DIGITS{SEL_ACTIVE_LOW}};
         seg_q      <= {8{SEG_ACTIVE_LOW}};
         ft_q       <= 1'b0;
      end else begin
         pcnt_q     <= pcnt_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         bph_q      <= bph_d;
         wcnt_q     <= wcnt_d;
         num_sh_q   <= num_sh_d;
         point_sh_q <= point_sh_d;
         blink_sh_q <= blink_sh_d;
         hex_sh_q   <= hex_sh_d;
         lz_sh_q    <= lz_sh_d;
         sel_q      <= SEL_ACTIVE_LOW ? ~sel_int : sel_int;
         seg_q      <= SEG_ACTIVE_LOW ? ~seg_int : seg_int;
         ft_q       <= snap;
      end
   end

   assign sel        = sel_q;
   assign seg_led    = seg_q;
   assign frame_tick = ft_q;

endmodule
